// File: rtl/reg_bank_pkg.sv
// Shared types and default sizing for the multi-port register bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int W_DEF   = 7;
  localparam int N_DEF   = 4;
  localparam int NRD_DEF = 2;
  localparam int NWR_DEF = 2;

endpackage

// File: rtl/reg_bank_clear_fsm.sv
// Sequential clear engine: walks every bank address once, one per cycle.
// Latency: busy rises the cycle after clear is sampled in IDLE; 2**N cycles in CLEAR.
// Backpressure: clear requests seen while CLEAR is active are ignored (no re-trigger).
module reg_bank_clear_fsm
  import reg_bank_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_clr_vld,
  output logic [N-1:0] o_clr_addr
);

  // Last address zeroed, and the one before it (done is registered, so it
  // has to be armed one cycle early to line up with the final clear cycle).
  localparam logic [N-1:0] C_LAST   = '1;
  localparam logic [N-1:0] C_PENULT = C_LAST - N'(1);

  clr_state_t   r_state;
  logic [N-1:0] r_cnt;
  logic         r_busy;
  logic         r_done;

  // State, address counter and the registered busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt  <= '0;
          r_done <= 1'b0;
          if (i_clear) begin
            r_state <= CLEAR;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          r_cnt  <= r_cnt + N'(1);
          r_done <= (r_cnt == C_PENULT);
          if (r_cnt == C_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_clr_vld  = (r_state == CLEAR);
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-port register bank: NWR prioritised write ports, NRD registered read ports with write bypass.
// Latency: 1 cycle address-to-rs, write-first (same-cycle writes and clears are visible).
// Backpressure: none; writes are silently dropped while the clear engine is busy.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int N        = N_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int NWR      = NWR_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NWR-1:0]         we,
  input  logic [NWR-1:0][N-1:0]  addr_rd,
  input  logic [NWR-1:0][W-1:0]  data_in,
  input  logic [NRD-1:0][N-1:0]  addr_rs,
  output logic [NRD-1:0][W-1:0]  rs,
  input  logic                   clear,
  output logic                   busy,
  output logic                   done
);

  localparam int DEPTH = 2 ** N;

  logic [W-1:0]          r_mem [DEPTH];
  logic [W-1:0]          w_nxt [DEPTH];
  logic [NRD-1:0][W-1:0] r_rs;
  logic                  w_clr_vld;
  logic [N-1:0]          w_clr_addr;

  reg_bank_clear_fsm #(
    .N (N)
  ) u_clear_fsm (
    .clk        (clk),
    .rst_n      (reset),
    .i_clear    (clear),
    .o_busy     (busy),
    .o_done     (done),
    .o_clr_vld  (w_clr_vld),
    .o_clr_addr (w_clr_addr)
  );

  // Next content of every register: ascending port loop makes the highest
  // write port win; the clear strobe and the hardwired zero override writes.
  // Reads index this same vector, which gives the write-first bypass for free.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      w_nxt[j] = r_mem[j];
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && !w_clr_vld && (addr_rd[i] == N'(j))) begin
          w_nxt[j] = data_in[i];
        end
      end
      if (w_clr_vld && (w_clr_addr == N'(j))) begin
        w_nxt[j] = '0;
      end
      if (ZERO_REG && (j == 0)) begin
        w_nxt[j] = '0;
      end
    end
  end

  // Storage update and registered read ports.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_mem[j] <= '0;
      end
      r_rs <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        r_mem[j] <= w_nxt[j];
      end
      for (int k = 0; k < NRD; k++) begin
        r_rs[k] <= w_nxt[addr_rs[k]];
      end
    end
  end

  assign rs = r_rs;

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed bench for reg_bank_mp with a per-cycle reference model and literal checks.
module tb_reg_bank_mp;
  import reg_bank_pkg::*;

  localparam int W     = 7;
  localparam int N     = 4;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int DEPTH = 16;

  logic                  clk     = 1'b0;
  logic                  reset   = 1'b0;
  logic [NWR-1:0]        we      = '0;
  logic [NWR-1:0][N-1:0] addr_rd = '0;
  logic [NWR-1:0][W-1:0] data_in = '0;
  logic [NRD-1:0][N-1:0] addr_rs = '0;
  logic [NRD-1:0][W-1:0] rs;
  logic                  clear   = 1'b0;
  logic                  busy;
  logic                  done;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  reg_bank_mp #(
    .W(W), .N(N), .NRD(NRD), .NWR(NWR), .ZERO_REG(1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .addr_rd (addr_rd),
    .data_in (data_in),
    .addr_rs (addr_rs),
    .rs      (rs),
    .clear   (clear),
    .busy    (busy),
    .done    (done)
  );

  // 10 MHz clock
  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The bank as a plain array; a clear is a countdown of cycles left, and the
  // register cleared on a given cycle is simply DEPTH - cycles_left.
  logic [W-1:0] m_mem [DEPTH];
  logic [W-1:0] m_nm  [DEPTH];
  logic [W-1:0] m_rs  [NRD];
  int           m_left = 0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < DEPTH; j++) m_mem[j] = '0;
      for (int k = 0; k < NRD; k++) m_rs[k] = '0;
      m_left = 0;
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      for (int j = 0; j < DEPTH; j++) m_nm[j] = m_mem[j];
      if (m_left == 0) begin
        for (int i = 0; i < NWR; i++) if (we[i]) m_nm[addr_rd[i]] = data_in[i];
      end else begin
        m_nm[DEPTH - m_left] = '0;
      end
      m_nm[0] = '0;
      for (int k = 0; k < NRD; k++) m_rs[k] = m_nm[addr_rs[k]];
      if (m_left == 0) begin
        if (clear) m_left = DEPTH;
      end else begin
        m_left = m_left - 1;
      end
      m_busy = (m_left != 0);
      m_done = (m_left == 1);
      for (int j = 0; j < DEPTH; j++) m_mem[j] = m_nm[j];
    end
  end

  // Compare DUT outputs against the model every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NRD; k++) check($sformatf("model_rs%0d", k), rs[k], m_rs[k]);
      check("model_busy", busy, m_busy);
      check("model_done", done, m_done);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reg(input string name, input int a, input logic [W-1:0] exp);
    we         = '0;
    addr_rs[0] = N'(a);
    step();
    check($sformatf("%s_r%0d", name, a), rs[0], exp);
  endtask

  initial begin
    repeat (2) step();
    chk_en = 1'b1;
    reset  = 1'b1;
    step();

    // 1: reset asserted mid-traffic
    we = 2'b11; addr_rd[0] = 4'd6; addr_rd[1] = 4'd9;
    data_in[0] = 7'h15; data_in[1] = 7'h3C;
    addr_rs[0] = 4'd6; addr_rs[1] = 4'd9;
    step();
    we = '0;
    step();
    check("t1_pre_rs0", rs[0], 7'h15);
    check("t1_pre_rs1", rs[1], 7'h3C);
    #20 reset = 1'b0;
    #1;
    check("t1_rst_rs0", rs[0], 0);
    check("t1_rst_rs1", rs[1], 0);
    check("t1_rst_busy", busy, 0);
    check("t1_rst_done", done, 0);
    step();
    reset = 1'b1;
    for (int a = 0; a < DEPTH; a++) check_reg("t1", a, '0);

    // 2: single write then read
    we = 2'b01; addr_rd[0] = 4'd3; data_in[0] = 7'h2A;
    step();
    check_reg("t2", 3, 7'h2A);

    // 3: both ports hit the same address, read in the same cycle
    we = 2'b11; addr_rd[0] = 4'd5; addr_rd[1] = 4'd5;
    data_in[0] = 7'h11; data_in[1] = 7'h22; addr_rs[1] = 4'd5;
    step();
    check("t3_bypass_rs1", rs[1], 7'h22);
    check_reg("t3", 5, 7'h22);

    // 4: hardwired zero register
    we = 2'b01; addr_rd[0] = 4'd0; data_in[0] = 7'h7F; addr_rs[0] = 4'd0;
    step();
    check("t4_bypass_rs0", rs[0], 0);
    check_reg("t4", 0, '0);

    // 5: fill, clear, writes during busy are lost
    for (int j = 1; j < DEPTH; j++) begin
      we = 2'b01; addr_rd[0] = N'(j); data_in[0] = W'(j + 1);
      step();
    end
    check_reg("t5_fill", 1, 7'd2);
    check_reg("t5_fill", 15, 7'd16);
    clear = 1'b1;
    step();
    for (int c = 1; c <= DEPTH; c++) begin
      check($sformatf("t5_busy_c%0d", c), busy, 1);
      check($sformatf("t5_done_c%0d", c), done, (c == DEPTH) ? 1 : 0);
      we = 2'b11;
      addr_rd[0] = N'(c + 14); data_in[0] = 7'h55;
      addr_rd[1] = N'(c + 3);  data_in[1] = 7'h66;
      addr_rs[0] = N'(c - 1);
      addr_rs[1] = N'(c);
      if (c == DEPTH) clear = 1'b0;
      step();
      check($sformatf("t5_clr_rs0_c%0d", c), rs[0], 0);
      check($sformatf("t5_clr_rs1_c%0d", c), rs[1], (c < DEPTH) ? (c + 1) : 0);
    end
    we = '0;
    check("t5_end_busy", busy, 0);
    check("t5_end_done", done, 0);
    for (int a = 0; a < DEPTH; a++) check_reg("t5", a, '0);

    // 6: reset in the middle of a clear
    we = 2'b11; addr_rd[0] = 4'd12; data_in[0] = 7'h33; addr_rd[1] = 4'd8; data_in[1] = 7'h22;
    step();
    we = 2'b01; addr_rd[0] = 4'd3; data_in[0] = 7'h11;
    step();
    we = '0;
    check_reg("t6_fill", 12, 7'h33);
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (6) step();
    check("t6_mid_busy", busy, 1);
    #20 reset = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_rs0", rs[0], 0);
    step();
    step();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("t6_idle_busy_%0d", c), busy, 0);
    end
    check_reg("t6", 3, '0);
    check_reg("t6", 8, '0);
    check_reg("t6", 12, '0);
    check_reg("t6", 15, '0);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
